// File: rtl/dct_mac_sequencer_if.sv
// dct_mac_sequencer_if: row-vector accept, MAC strobe and coefficient handoff signals of one DCT MAC unit
// Build option DCT_MAC_SEQ_PERF_EN adds the blk_cnt/stall_cnt performance counters.
interface dct_mac_sequencer_if #(
  parameter int TW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] tap_sel;
  logic          mac_en;
  logic          mac_clr;
  logic          res_ld;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
`ifdef DCT_MAC_SEQ_PERF_EN
  logic [15:0]   blk_cnt;
  logic [15:0]   stall_cnt;
  modport master (
    input  in_valid, out_ready,
    output in_ready, tap_sel, mac_en, mac_clr, res_ld, out_valid, busy, blk_cnt, stall_cnt
  );
  modport slave (
    output in_valid, out_ready,
    input  in_ready, tap_sel, mac_en, mac_clr, res_ld, out_valid, busy, blk_cnt, stall_cnt
  );
`else
  modport master (
    input  in_valid, out_ready,
    output in_ready, tap_sel, mac_en, mac_clr, res_ld, out_valid, busy
  );
  modport slave (
    output in_valid, out_ready,
    input  in_ready, tap_sel, mac_en, mac_clr, res_ld, out_valid, busy
  );
`endif
endinterface

// File: rtl/dct_mac_sequencer.sv
// dct_mac_sequencer: steps one DCT MAC through TAPS taps, drains its pipeline, loads and hands off the coefficient
// Build option DCT_MAC_SEQ_PERF_EN adds the handoff and HOLD-stall counters.
module dct_mac_sequencer #(
  parameter int TAPS    = 8,
  parameter int MAC_LAT = 2,
  parameter int TW      = $clog2(TAPS)
) (
  input logic                   clk,
  input logic                   rst_n,
  input logic                   ena,
  input logic                   flush,
  dct_mac_sequencer_if.master   bus
);
  typedef enum logic [2:0] {IDLE, ACC, DRAIN, LOAD, HOLD} state_t;
  localparam logic [TW-1:0] TLAST = TW'(TAPS - 1);
  localparam logic [2:0]    DLAST = 3'(MAC_LAT == 0 ? 0 : MAC_LAT - 1);
  state_t        state;
  logic [TW-1:0] tap;
  logic [2:0]    drn;
  logic          go;
  assign go            = ena & ~flush;
  // rst_n masks in_ready so nothing is offered while the block is held in reset
  assign bus.in_ready  = (state == IDLE) & go & rst_n;
  assign bus.mac_en    = (state == ACC) & go;
  assign bus.mac_clr   = (state == ACC) & go & (tap == '0);
  assign bus.tap_sel   = (state == ACC) ? tap : '0;
  assign bus.res_ld    = (state == LOAD) & go;
  assign bus.out_valid = (state == HOLD) & ~flush;
  assign bus.busy      = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tap   <= '0;
      drn   <= '0;
    end else if (flush) begin
      state <= IDLE;
      tap   <= '0;
      drn   <= '0;
    end else if (ena) begin
      case (state)
        IDLE: if (bus.in_valid) begin
          state <= ACC;
          tap   <= '0;
        end
        ACC: begin
          tap <= tap + 1'b1;
          if (tap == TLAST) begin
            state <= (MAC_LAT == 0) ? LOAD : DRAIN;
            drn   <= '0;
          end
        end
        DRAIN: begin
          drn <= drn + 1'b1;
          if (drn == DLAST) state <= LOAD;
        end
        LOAD:    state <= HOLD;
        HOLD:    if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef DCT_MAC_SEQ_PERF_EN
  // handoffs wrap, stalls saturate; flush clears neither
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.blk_cnt   <= '0;
      bus.stall_cnt <= '0;
    end else begin
      if ((state == HOLD) & go & bus.out_ready) bus.blk_cnt <= bus.blk_cnt + 1'b1;
      if ((state == HOLD) & ena & ~bus.out_ready & ~&bus.stall_cnt) bus.stall_cnt <= bus.stall_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_dct_mac_sequencer.sv
// tb_dct_mac_sequencer: two sequencers (8 taps/lat 2 and 4 taps/lat 0) against a progress-count reference model
// Perf counters are also checked when DCT_MAC_SEQ_PERF_EN is defined.
module tb_dct_mac_sequencer;
  logic clk = 0, rst_n = 0, ena = 1, flush = 0, in_valid = 0, out_ready = 1;
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  int p[2], blk[2], stall[2];
  logic [8:0] a0, a1, o0, o1;
  dct_mac_sequencer_if #(.TW(3)) b0();
  dct_mac_sequencer_if #(.TW(2)) b1();
  assign b0.in_valid = in_valid;
  assign b0.out_ready = out_ready;
  assign b1.in_valid = in_valid;
  assign b1.out_ready = out_ready;
  dct_mac_sequencer #(.TAPS(8), .MAC_LAT(2)) u0 (.clk(clk), .rst_n(rst_n), .ena(ena), .flush(flush), .bus(b0));
  dct_mac_sequencer #(.TAPS(4), .MAC_LAT(0)) u1 (.clk(clk), .rst_n(rst_n), .ena(ena), .flush(flush), .bus(b1));
  assign a0 = {b0.busy, b0.in_ready, b0.mac_en, b0.mac_clr, b0.tap_sel, b0.res_ld, b0.out_valid};
  assign a1 = {b1.busy, b1.in_ready, b1.mac_en, b1.mac_clr, 1'b0, b1.tap_sel, b1.res_ld, b1.out_valid};
  function automatic int tp(int i); return i == 0 ? 8 : 4; endfunction
  function automatic int hold_at(int i); return i == 0 ? 12 : 6; endfunction
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask
  // p = enabled cycles since accept; every output follows from where p sits in the spec's timeline
  function automatic logic [8:0] model_out(int i);
    int q = p[i];
    int h = hold_at(i);
    logic g = ena & ~flush;
    logic [2:0] ts = (q >= 1 && q <= tp(i)) ? 3'(q - 1) : 3'd0;
    return {q != 0, q == 0 && g && rst_n, q >= 1 && q <= tp(i) && g, q == 1 && g, ts, q == h - 1 && g, q == h && !flush};
  endfunction
  task automatic cycle();
    @(negedge clk);
    if (!rst_n) begin
      p = '{0, 0};
      blk = '{0, 0};
      stall = '{0, 0};
    end
    o0 = a0;
    o1 = a1;
    chk("u0_outputs", int'(a0), int'(model_out(0)));
    chk("u1_outputs", int'(a1), int'(model_out(1)));
`ifdef DCT_MAC_SEQ_PERF_EN
    chk("u0_blk_cnt", int'(b0.blk_cnt), blk[0]);
    chk("u0_stall_cnt", int'(b0.stall_cnt), stall[0]);
    chk("u1_blk_cnt", int'(b1.blk_cnt), blk[1]);
    chk("u1_stall_cnt", int'(b1.stall_cnt), stall[1]);
`endif
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        blk[i] = 0;
        stall[i] = 0;
        p[i] = 0;
      end else begin
        if (p[i] == hold_at(i) && ena && !out_ready && stall[i] != 65535) stall[i]++;
        if (p[i] == hold_at(i) && ena && !flush && out_ready) blk[i] = (blk[i] + 1) % 65536;
        if (flush) p[i] = 0;
        else if (ena) p[i] = (p[i] == 0) ? int'(in_valid) : (p[i] == hold_at(i)) ? (out_ready ? 0 : p[i]) : p[i] + 1;
      end
    end
    #1;
  endtask
  task automatic wait_idle();
    rst_n = 1; ena = 1; flush = 0; in_valid = 0; out_ready = 1;
    for (int k = 0; k < 40 && (b0.busy || b1.busy); k++) cycle();
    chk("idle_timeout", int'(b0.busy | b1.busy), 0);
    cycle();
  endtask
  typedef struct {logic iv; logic [7:0] exp;} vec_t;
  vec_t tbl[14];
  int r1, v1, n_en, n_ov, n_ir, bad, res_c, s_snap, b_snap;
  int acc[$];
  initial begin
    for (int c = 0; c < 14; c++) begin
      tbl[c].iv = (c == 0);
      tbl[c].exp = {c == 0 || c == 13, c >= 1 && c <= 8, c == 1, (c >= 1 && c <= 8) ? 3'(c - 1) : 3'd0, c == 11, c == 12};
    end
    #1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("reset_u0", int'(o0), 0);
      chk("reset_u1", int'(o1), 0);
    end
    rst_n = 1;
    cycle();
    chk("ready_after_reset", int'(o0[7]), 1);
    r1 = -1; v1 = -1;
    for (int c = 0; c < 14; c++) begin
      in_valid = tbl[c].iv;
      cycle();
      chk($sformatf("vec_row%0d", c), int'(o0[7:0]), int'(tbl[c].exp));
      if (o1[1] && r1 < 0) r1 = c;
      if (o1[0] && v1 < 0) v1 = c;
    end
    chk("u1_res_ld_cycle", r1, 5);
    chk("u1_out_valid_cycle", v1, 6);
    wait_idle();
    n_ov = 0; n_ir = 0;
`ifdef DCT_MAC_SEQ_PERF_EN
    s_snap = int'(b0.stall_cnt); b_snap = int'(b0.blk_cnt);
`endif
    for (int c = 0; c < 20; c++) begin
      in_valid = (c == 0);
      out_ready = !(c >= 12 && c <= 16);
      cycle();
      n_ov += int'(o0[0]);
      if (c >= 1 && c <= 17) n_ir += int'(o0[7]);
    end
    chk("stall_out_valid_cycles", n_ov, 6);
    chk("stall_in_ready_low", n_ir, 0);
`ifdef DCT_MAC_SEQ_PERF_EN
    chk("stall_cnt_delta", int'(b0.stall_cnt) - s_snap, 5);
    chk("blk_cnt_delta", int'(b0.blk_cnt) - b_snap, 1);
`endif
    wait_idle();
    n_en = 0; res_c = -1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c == 0);
      ena = !(c >= 5 && c <= 7);
      cycle();
      if (c >= 5 && c <= 7) n_en += int'(o0[6]);
      if (c == 8) chk("pause_resume_tap", int'(o0[4:2]), 4);
      if (o0[1] && res_c < 0) res_c = c;
    end
    chk("pause_mac_en", n_en, 0);
    chk("pause_res_ld_cycle", res_c, 14);
    wait_idle();
    bad = 0;
    for (int c = 0; c < 16; c++) begin
      in_valid = (c == 0);
      flush = (c == 7);
      cycle();
      if (c == 7) chk("flush_mac_en", int'(o0[6]), 0);
      if (c == 8) chk("flush_ready_next", int'(o0[7]), 1);
      if (c >= 7) bad += int'(o0[1] | o0[0]);
    end
    chk("flush_no_result", bad, 0);
    wait_idle();
    bad = 0;
    for (int c = 0; c < 16; c++) begin
      in_valid = (c == 0);
      rst_n = !(c == 9);
      cycle();
      if (c == 10) chk("reset_ready_next", int'(o0[7]), 1);
      if (c >= 9) bad += int'(o0[1] | o0[0]);
    end
    chk("reset_no_result", bad, 0);
    wait_idle();
`ifdef DCT_MAC_SEQ_PERF_EN
    b_snap = int'(b0.blk_cnt);
`endif
    for (int c = 0; c < 45; c++) begin
      in_valid = 1;
      cycle();
      if (o0[7]) acc.push_back(c);
    end
    chk("b2b_accepts", acc.size(), 4);
    for (int k = 0; k < acc.size(); k++) chk($sformatf("b2b_accept%0d", k), acc[k], 13 * k);
`ifdef DCT_MAC_SEQ_PERF_EN
    chk("b2b_blk_delta", int'(b0.blk_cnt) - b_snap, 3);
`endif
    wait_idle();
    for (int c = 0; c < 3000; c++) begin
      rst_n = $urandom_range(0, 299) != 0;
      ena = $urandom_range(0, 7) != 0;
      flush = $urandom_range(0, 39) == 0;
      in_valid = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      cycle();
    end
    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dct_mac_sequencer.md
# dct_mac_sequencer

Sequences one DCT multiply-accumulate unit inside `fdct_zigzag.dct_mod.dct_block_N.dct_unit_M`. It accepts one 8-sample row-vector per handshake and drives tap select, accumulator clear and enable for `TAPS` cycles. It then waits for the MAC pipeline to drain, strobes the load into `macu.result`, and presents the loaded coefficient downstream under a valid/ready handshake.

## Interface
- `TAPS`, default 8: products accumulated per coefficient; must be a power of two, ≥2.
- `MAC_LAT`, default 2: cycles from `mac_en` to the product reaching the accumulator; range 0..7.
- `TW`, default `$clog2(TAPS)`: tap select width.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: global clock-enable; 0 freezes the block.
- `flush` in 1: synchronous abort to IDLE.
- `in_valid` in 1: upstream row buffer holds a complete vector.
- `in_ready` out 1: sequencer accepts a vector.
- `tap_sel` out TW: sample/coefficient index for the MAC.
- `mac_en` out 1: MAC performs one multiply-accumulate this cycle.
- `mac_clr` out 1: accumulator takes the product and discards the old sum; asserted with the first tap only.
- `res_ld` out 1: load enable for `macu.result`.
- `out_valid` out 1: `macu.result` holds a new coefficient.
- `out_ready` in 1: downstream consumes the coefficient.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, ACC, DRAIN, LOAD, HOLD. Internal counters: `tap` (TW bits) and `drn` (3 bits).
- IDLE: `in_ready = ena & ~flush`. When `in_valid & in_ready`, go to ACC with `tap=0`.
- ACC: `mac_en=1`, `tap_sel=tap`, `mac_clr=(tap==0)`, and `tap` increments. At `tap==TAPS-1`, go to DRAIN with `drn=0`, or go straight to LOAD if `MAC_LAT==0`.
- DRAIN: all strobes are 0 and `drn` increments. At `drn==MAC_LAT-1`, go to LOAD.
- LOAD: `res_ld=1` for exactly one cycle, then go to HOLD.
- HOLD: `out_valid=1`, held stable until `out_ready`. On `out_valid & out_ready`, go to IDLE.
- `in_ready` is 0 in every state except IDLE. A new vector is never accepted in the cycle its predecessor is handed off.
- `ena=0`: state and counters are frozen. `mac_en`, `mac_clr`, `res_ld` and `in_ready` are forced to 0. `out_valid` holds its value, and a handoff is not counted while `ena=0`.
- `flush=1`: next state is IDLE from any state and all strobes are forced to 0 that cycle. `flush` takes priority over `ena=0` and over a simultaneous handshake.
- `tap_sel` outside ACC is 0.
- `rst_n` low at any time, including mid-ACC: return to IDLE immediately. The partial sum is abandoned and `res_ld` is not issued.

## Timing
- Reset values: `in_ready=0`, `tap_sel=0`, `mac_en=0`, `mac_clr=0`, `res_ld=0`, `out_valid=0`, `busy=0`. `in_ready` rises the first cycle after deassertion that has `ena=1`.
- Strobe timing, counting the accept edge as edge 0:
  - `mac_en` is high for cycles 1..TAPS.
  - `res_ld` is high in cycle TAPS+MAC_LAT+1.
  - `out_valid` rises in cycle TAPS+MAC_LAT+2.
- Defaults (TAPS=8, MAC_LAT=2): `res_ld` in cycle 11, `out_valid` in cycle 12.
- Maximum throughput is one vector per TAPS+MAC_LAT+3 cycles (13 cycles at defaults) with `out_ready` tied high.
- All outputs are registered-state decodes. There is no combinational path from `out_ready` or `in_valid` to any output except `in_ready`, which depends on `ena` and `flush` only.

## Configuration
- `DCT_MAC_SEQ_PERF_EN` defined: adds two output ports.
  - `blk_cnt` (16 bits): counts handoffs and wraps at 65535→0.
  - `stall_cnt` (16 bits): counts HOLD cycles with `ena=1 & out_ready=0` and saturates at 65535.
  - Both counters reset to 0 on `rst_n` and are unaffected by `flush`.
- `DCT_MAC_SEQ_PERF_EN` undefined: both ports and their logic are absent. Sequencing behaviour is identical in both builds.

## Test plan
- Reset release, single vector, `out_ready=1`, defaults:
  - `mac_clr` high only in cycle 1, `mac_en` high in cycles 1–8, `tap_sel` runs 0..7.
  - `res_ld` high in cycle 11 only, `out_valid` high in cycle 12 only, `in_ready` back to 1 in cycle 13.
- `out_ready` low for 5 cycles in HOLD:
  - `out_valid` stays high for 6 cycles.
  - `in_ready` stays 0 throughout.
  - With `PERF_EN`: `stall_cnt=5`, `blk_cnt=1`.
- `ena=0` for 3 cycles at `tap=4`:
  - No `mac_en` during the pause.
  - Taps resume at 4, and `res_ld` shifts to cycle 14.
- `flush` at `tap=6`, and separately `rst_n` pulse in DRAIN:
  - No `res_ld` or `out_valid` follows.
  - `in_ready=1` on the next cycle (after `flush`) or on the first cycle after reset release (after `rst_n`).
- Parameter sweep with MAC_LAT=0, TAPS=4: `res_ld` in cycle 5 and `out_valid` in cycle 6.
- Back-to-back vectors with `in_valid` held high: accept edges are 13 cycles apart, and `blk_cnt` increments once per handoff.
